// File: rtl/up_core_param.sv
// Parametrised accumulator core: external program ROM, data memory behind a
// request/ready handshake, run gating and an output strobe.
//
// state   | meaning
// FETCH   | latch opcode/operand from prog_data, PC += 1 (only while run)
// EXEC    | execute one-word ops and jumps, or launch a data access
// MEM     | hold the data request until dmem_ready, then complete the op
module up_core_param #(
  parameter  int DATA_W = 4,
  localparam int ADDR_W = 2*DATA_W + 4,
  localparam int PW     = DATA_W + 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [PW-1:0]     prog_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] accu,
  output logic              c_flag,
  output logic              z_flag,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [3:0]          instr;
  logic [DATA_W-1:0]   oprnd;
  logic [ADDR_W-1:0]   target;
  logic                is_jump, is_mem, jump_taken;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W:0]     alu_res;
  logic                alu_wr_accu, alu_wr_flags, commit;

  assign prog_addr  = pc;
  assign dmem_wdata = accu;
  assign state      = state_q;
  assign target     = {oprnd, prog_data};

  always_comb begin
    is_jump    = instr inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP};
    is_mem     = instr inside {OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM};
    jump_taken = 1'b0;
    case (instr)
      OP_JC:   jump_taken = c_flag;
      OP_JNC:  jump_taken = !c_flag;
      OP_JZ:   jump_taken = z_flag;
      OP_JNZ:  jump_taken = !z_flag;
      OP_JMP:  jump_taken = 1'b1;
      default: jump_taken = 1'b0;
    endcase
  end

  // Immediate ops take their operand in EXEC; memory ops reuse the same
  // datapath in MEM with the returned read data.
  always_comb begin
    alu_b        = (state_q == S_MEM) ? dmem_rdata : oprnd;
    alu_res      = '0;
    alu_wr_accu  = 1'b0;
    alu_wr_flags = 1'b0;
    case (instr)
      OP_CMPI, OP_CMPM: begin
        alu_res      = {1'b0, accu} - {1'b0, alu_b};
        alu_wr_flags = 1'b1;
      end
      OP_LIT, OP_LD: begin
        alu_res      = {1'b0, alu_b};
        alu_wr_accu  = 1'b1;
        alu_wr_flags = 1'b1;
      end
      OP_IN: begin
        alu_res      = {1'b0, in_data};
        alu_wr_accu  = 1'b1;
        alu_wr_flags = 1'b1;
      end
      OP_ADDI, OP_ADDM: begin
        alu_res      = {1'b0, accu} + {1'b0, alu_b};
        alu_wr_accu  = 1'b1;
        alu_wr_flags = 1'b1;
      end
      OP_NANDI, OP_NANDM: begin
        alu_res      = {1'b0, ~(accu & alu_b)};
        alu_wr_accu  = 1'b1;
        alu_wr_flags = 1'b1;
      end
      default: ;
    endcase
    commit = ((state_q == S_EXEC) && !is_jump && !is_mem) ||
             ((state_q == S_MEM) && dmem_ready);
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH: if (run) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_mem ? S_MEM : S_FETCH;
      S_MEM:   if (dmem_ready) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      instr     <= '0;
      oprnd     <= '0;
      accu      <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      dmem_addr <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run) begin
            instr <= prog_data[DATA_W+3:DATA_W];
            oprnd <= prog_data[DATA_W-1:0];
            pc    <= pc + PC_ONE;
          end
        end
        S_EXEC: begin
          if (is_jump) begin
            pc <= jump_taken ? target : pc + PC_ONE;
          end else if (is_mem) begin
            dmem_addr <= target;
            dmem_req  <= 1'b1;
            dmem_we   <= (instr == OP_ST);
          end else if (instr == OP_OUT) begin
            out_data  <= accu;
            out_valid <= 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= pc + PC_ONE;
          end
        end
        default: ;
      endcase
      if (commit) begin
        if (alu_wr_accu) accu <= alu_res[DATA_W-1:0];
        if (alu_wr_flags) begin
          c_flag <= alu_res[DATA_W];
          z_flag <= (alu_res[DATA_W-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_up_core_param.sv
// Bench for up_core_param at DATA_W=4: an instruction-level model predicts
// every cycle of each instruction, and a negedge process compares the core.
module tb_up_core_param;
  localparam int DW = 4;
  localparam int AW = 12;
  localparam int IN_VAL = 11;

  logic          clock = 1'b0;
  logic          reset, run;
  logic [AW-1:0] prog_addr;
  logic [DW+3:0] prog_data;
  logic          dmem_req, dmem_we, dmem_ready;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata, in_data, out_data, accu;
  logic          out_valid, c_flag, z_flag;
  logic [1:0]    state;

  logic [7:0] rom  [0:4095];
  logic [3:0] dmem [0:4095];

  assign prog_data  = rom[prog_addr];
  assign dmem_rdata = dmem[dmem_addr];

  up_core_param #(.DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .accu(accu), .c_flag(c_flag), .z_flag(z_flag), .state(state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pc = 0, m_acc = 0, m_c = 0, m_z = 0, m_out = 0, m_addr = 0;
  int exp_state = 0, exp_pc = 0, exp_req = 0, exp_we = 0, exp_addr = 0;
  int exp_acc = 0, exp_c = 0, exp_z = 0, exp_out = 0, exp_ov = 0;
  bit chk_en = 1'b0;
  int req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("state",      32'(state),      exp_state);
      check("prog_addr",  32'(prog_addr),  exp_pc);
      check("dmem_req",   32'(dmem_req),   exp_req);
      if (exp_req != 0) check("dmem_we", 32'(dmem_we), exp_we);
      check("dmem_addr",  32'(dmem_addr),  exp_addr);
      check("dmem_wdata", 32'(dmem_wdata), exp_acc);
      check("accu",       32'(accu),       exp_acc);
      check("c_flag",     32'(c_flag),     exp_c);
      check("z_flag",     32'(z_flag),     exp_z);
      check("out_data",   32'(out_data),   exp_out);
      check("out_valid",  32'(out_valid),  exp_ov);
      if (dmem_req) req_cycles++;
    end
  end

  // Execute the instruction at m_pc; wait_n = MEM cycles with ready low.
  task automatic exec_one(input int wait_n);
    int w1, w2, op, opr, pc1, tgt, b, r;
    int n_pc, n_acc, n_c, n_z, n_out, n_ov;
    bit is_mem, is_jmp, taken;
    w1  = int'(rom[m_pc]);
    op  = w1 / 16;
    opr = w1 % 16;
    pc1 = (m_pc + 1) % 4096;
    w2  = int'(rom[pc1]);
    tgt = opr * 256 + w2;
    is_mem = (op == 3) || (op == 6) || (op == 7) || (op == 11) || (op == 15);
    is_jmp = (op == 0) || (op == 1) || (op == 8) || (op == 9) || (op == 12);
    b = is_mem ? int'(dmem[tgt]) : opr;
    n_acc = m_acc; n_c = m_c; n_z = m_z; n_out = m_out; n_ov = 0;
    n_pc  = is_mem ? (pc1 + 1) % 4096 : pc1;
    if (is_jmp) begin
      taken = (op == 12) || (op == 0 && m_c == 1) || (op == 1 && m_c == 0) ||
              (op == 8 && m_z == 1) || (op == 9 && m_z == 0);
      n_pc = taken ? tgt : (pc1 + 1) % 4096;
    end
    case (op)
      2, 3: begin
        r = m_acc - b;
        n_c = (r < 0) ? 1 : 0;
        n_z = ((r + 16) % 16 == 0) ? 1 : 0;
      end
      4, 6: begin n_acc = b; n_c = 0; n_z = (b == 0) ? 1 : 0; end
      5:    begin n_acc = IN_VAL; n_c = 0; n_z = (IN_VAL == 0) ? 1 : 0; end
      10, 11: begin
        r = m_acc + b;
        n_c = (r > 15) ? 1 : 0;
        n_acc = r % 16;
        n_z = (n_acc == 0) ? 1 : 0;
      end
      13: begin n_out = m_acc; n_ov = 1; end
      14, 15: begin
        n_acc = 15 - (m_acc & b);
        n_c = 0;
        n_z = (n_acc == 0) ? 1 : 0;
      end
      default: ;
    endcase

    run = 1'b1;
    @(posedge clock); #1;
    exp_ov = 0; exp_state = 1; exp_pc = pc1;
    // ready outside MEM must be ignored
    dmem_ready = is_mem ? 1'b0 : 1'b1;
    if (is_mem) begin
      for (int k = 0; k <= wait_n; k++) begin
        @(posedge clock); #1;
        exp_state = 2; exp_req = 1; exp_we = (op == 7) ? 1 : 0;
        exp_addr = tgt; m_addr = tgt;
        dmem_ready = (k == wait_n);
      end
    end
    @(posedge clock); #1;
    dmem_ready = 1'b0;
    if (op == 7) dmem[tgt] = 4'(m_acc);
    m_pc = n_pc; m_acc = n_acc; m_c = n_c; m_z = n_z; m_out = n_out;
    exp_state = 0; exp_pc = n_pc; exp_req = 0; exp_we = 0;
    exp_acc = n_acc; exp_c = n_c; exp_z = n_z; exp_out = n_out; exp_ov = n_ov;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      exp_ov = 0;
    end
  endtask

  task automatic load_memories();
    for (int a = 0; a < 4096; a++) begin
      rom[a]  = 8'h00;
      dmem[a] = 4'h0;
    end
    rom[12'h000] = 8'h45; rom[12'h001] = 8'hD0; rom[12'h002] = 8'h49;
    rom[12'h003] = 8'hA8; rom[12'h004] = 8'h21; rom[12'h005] = 8'h47;
    rom[12'h006] = 8'h73; rom[12'h007] = 8'hA5; rom[12'h008] = 8'h60;
    rom[12'h009] = 8'h12; rom[12'h00A] = 8'h81; rom[12'h00B] = 8'h00;
    rom[12'h100] = 8'h60; rom[12'h101] = 8'h13; rom[12'h102] = 8'h81;
    rom[12'h103] = 8'h00; rom[12'h104] = 8'h30; rom[12'h105] = 8'h20;
    rom[12'h106] = 8'hB0; rom[12'h107] = 8'h21; rom[12'h108] = 8'hF0;
    rom[12'h109] = 8'h22; rom[12'h10A] = 8'hEF; rom[12'h10B] = 8'h50;
    rom[12'h10C] = 8'h02; rom[12'h10D] = 8'h00; rom[12'h10E] = 8'h12;
    rom[12'h10F] = 8'h00; rom[12'h200] = 8'hAF; rom[12'h201] = 8'h03;
    rom[12'h202] = 8'h00; rom[12'h300] = 8'h94; rom[12'h301] = 8'h00;
    rom[12'h400] = 8'h2B; rom[12'h401] = 8'h1F; rom[12'h402] = 8'hFE;
    rom[12'h403] = 8'hCF; rom[12'h404] = 8'hFE; rom[12'hFFE] = 8'hCF;
    rom[12'hFFF] = 8'hFF;
    dmem[12'h012] = 4'h0; dmem[12'h013] = 4'h4; dmem[12'h020] = 4'h4;
    dmem[12'h021] = 4'hE; dmem[12'h022] = 4'h6;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; dmem_ready = 1'b0; in_data = 4'(IN_VAL);
    load_memories();
    repeat (2) @(posedge clock); #1;
    check("rst_state", 32'(state), 0);
    check("rst_pc",    32'(prog_addr), 0);
    check("rst_accu",  32'(accu), 0);
    check("rst_req",   32'(dmem_req), 0);
    check("rst_ov",    32'(out_valid), 0);
    check("rst_flags", 32'({c_flag, z_flag}), 0);
    reset = 1'b1;
    chk_en = 1'b1;

    exec_one(0); exec_one(0);                    // LIT 5 ; OUT
    check("lit_out_accu", 32'(accu), 5);
    check("lit_out_data", 32'(out_data), 5);
    check("lit_out_ov",   32'(out_valid), 1);
    check("lit_out_pc",   32'(prog_addr), 2);
    check("lit_out_cz",   32'({c_flag, z_flag}), 0);

    exec_one(0); exec_one(0);                    // LIT 9 ; ADDI 8
    check("addi_accu", 32'(accu), 1);
    check("addi_cz",   32'({c_flag, z_flag}), 32'b10);
    exec_one(0);                                 // CMPI 1
    check("cmpi_accu", 32'(accu), 1);
    check("cmpi_cz",   32'({c_flag, z_flag}), 32'b01);

    exec_one(0);                                 // LIT 7
    req_cycles = 0;
    exec_one(3);                                 // ST 0x3A5, 3 wait states
    check("st_req_cycles", 32'(req_cycles), 4);
    check("st_pc",         32'(prog_addr), 8);

    exec_one(0); exec_one(0);                    // LD 0x012 ; JZ 0x100
    check("jz_taken_pc", 32'(prog_addr), 12'h100);
    check("jz_taken_az", 32'({accu, z_flag}), 32'b00001);
    exec_one(2); exec_one(0);                    // LD 0x013 ; JZ 0x100
    check("jz_not_pc",   32'(prog_addr), 12'h104);
    check("jz_not_accu", 32'(accu), 4);

    exec_one(1); exec_one(0); exec_one(1);       // CMPM ; ADDM ; NANDM
    check("nandm_accu", 32'(accu), 4'hD);
    exec_one(0); exec_one(0);                    // NANDI F ; IN
    check("in_accu", 32'(accu), 4'hB);
    exec_one(0); exec_one(0);                    // JC (not) ; JNC (taken)
    check("jnc_pc", 32'(prog_addr), 12'h200);
    exec_one(0); exec_one(0); exec_one(0);       // ADDI F ; JC ; JNZ
    exec_one(0);                                 // CMPI B -> borrow
    check("cmpi_borrow", 32'({c_flag, z_flag}), 32'b10);
    exec_one(0); exec_one(0);                    // JNC (not) ; JMP 0xFFE
    exec_one(0);                                 // JMP 0xFFF
    check("jmp_fff_pc", 32'(prog_addr), 12'hFFF);
    exec_one(1);                                 // NANDM at 0xFFF, second word from 0x000
    check("wrap_pc", 32'(prog_addr), 12'h001);
    exec_one(0);                                 // OUT
    check("wrap_out", 32'(out_data), 4'hF);

    idle(5);
    check("idle_state", 32'(state), 0);
    check("idle_pc",    32'(prog_addr), 2);

    for (int i = 0; i < 4; i++) exec_one(0);     // LIT 9 ; ADDI ; CMPI ; LIT 7
    run = 1'b1;
    @(posedge clock); #1;
    exp_state = 1; exp_pc = 7; exp_ov = 0;
    dmem_ready = 1'b0;
    @(posedge clock); #1;
    exp_state = 2; exp_req = 1; exp_we = 1; exp_addr = 12'h3A5;
    #2;
    check("pre_rst_req", 32'(dmem_req), 1);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_req",   32'(dmem_req), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_pc",    32'(prog_addr), 0);
    check("mid_rst_accu",  32'(accu), 0);
    check("mid_rst_addr",  32'(dmem_addr), 0);
    check("mid_rst_misc",  32'({out_data, out_valid, c_flag, z_flag, dmem_we}), 0);
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
